// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: shares one full-adder cell (two half adders plus an OR)
// across N-bit operands, LSB first, with a start/busy/done handshake.

module half_adder (
   input  logic x_i,
   input  logic y_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = x_i ^ y_i;
   assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
   parameter int N  = 8,
   parameter int CW = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [N-1:0]    ra_q;
   logic [N-1:0]    rb_q;
   logic [N-1:0]    racc_q;
   logic [CW-1:0]   cnt_q;
   logic            c_q;
   logic            busy_q;
   logic            done_q;
   logic [N-1:0]    sum_q;
   logic            cout_q;

   logic            hs0_s;
   logic            hc0_s;
   logic            hc1_s;
   logic            bit_s;
   logic            c_d;
   logic [N-1:0]    racc_d;

   half_adder u_ha0 (.x_i(ra_q[0]), .y_i(rb_q[0]), .s_o(hs0_s), .c_o(hc0_s));
   half_adder u_ha1 (.x_i(hs0_s),   .y_i(c_q),     .s_o(bit_s), .c_o(hc1_s));

   assign c_d    = hc0_s | hc1_s;
   assign racc_d = {bit_s, racc_q[N-1:1]};

   // Handshake FSM with operand shifters, carry flop, bit counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         racc_q  <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  ra_q    <= a;
                  rb_q    <= b;
                  c_q     <= cin;
                  cnt_q   <= '0;
                  racc_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               ra_q   <= ra_q >> 1;
               rb_q   <= rb_q >> 1;
               c_q    <= c_d;
               racc_q <= racc_d;
               cnt_q  <= cnt_q + CW'(1);
               // Last bit: the freshly shifted accumulator is the final sum.
               if (cnt_q == CW'(N - 1)) begin
                  sum_q   <= racc_d;
                  cout_q  <= c_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  done_q  <= 1'b0;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: vector table plus hand-written multi-cycle sequences.

module tb_serial_add_ctrl;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.N(N), .CW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vcin;
      logic [7:0] esum;
      logic       ecout;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation from a point #1 after a rising edge; return after the done cycle.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                         input logic [7:0] esum, input logic ecout, input string tag);
      int e;
      int busy_low;
      a = ia; b = ib; cin = icin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      e = 1;
      busy_low = 0;
      if (busy !== 1'b1) busy_low++;
      while (done !== 1'b1 && e < 20) begin
         @(posedge clk); #1;
         e++;
         if (busy !== 1'b1) busy_low++;
      end
      check({tag, " latency"}, e, 9);
      check({tag, " busy_gaps"}, busy_low, 0);
      check({tag, " result"}, {cout, sum}, {ecout, esum});
      @(posedge clk); #1;
      check({tag, " idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int ndone;
      int cyc;
      int last;
      logic [7:0] hs;
      logic       hc;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
      vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      check("reset_outputs", {busy, done, cout, sum}, 11'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      check("idle_no_start", {busy, done, cout, sum}, 11'd0);

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum, vecs[i].ecout,
                $sformatf("vec%0d", i));

      // Result hold with start low.
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "hold_op");
      hs = sum; hc = cout;
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         @(posedge clk); #1;
         check("hold_stable", {done, busy, cout, sum}, {2'b00, 1'b1, 8'hFF});
      end

      // Starts during RUN and DONE must be ignored.
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 20) begin
         if (cyc == 3) begin
            a = 8'h01; b = 8'h01; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("ignore_latency", cyc, 9);
      a = 8'h01; b = 8'h01; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignore_result", {cout, sum}, 9'h030);
      ndone = 1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) ndone++;
         check("ignore_no_restart", busy, 1'b0);
      end
      check("ignore_done_count", ndone, 1);

      // Asynchronous reset in the middle of an operation.
      a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      check("pre_reset_busy", {busy, sum}, {1'b1, 8'h30});
      #2 rst = 1'b1;
      #1;
      check("async_reset", {busy, done, cout, sum}, 11'd0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_idle", {busy, done}, 2'b00);
      run_op(8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0, "after_reset");

      // Back-to-back with start held high.
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      ndone = 0; last = 0; cyc = 0;
      while (ndone < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (done === 1'b1) begin
            check("b2b_result", {cout, sum}, 9'h100);
            if (ndone == 0) check("b2b_first", cyc, 9);
            else            check("b2b_spacing", cyc - last, 10);
            last = cyc;
            ndone++;
         end
      end
      start = 1'b0;
      check("b2b_count", ndone, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
